sd_block_scheduler: RTL and testbench
=====================================

Name: sd_block_scheduler

Overview:
- Arbitrates one shared SD controller between NUM_TRACKS track store/load engines; each engine requests one 512-byte block transfer at a time.
- Keeps per-track write pointers (track length) and read pointers, and computes each block's SD byte address from a fixed per-track region.
- Sequences the controller's ready/rd/wr handshake and returns per-track ack, done and error pulses.

Parameters:
- NUM_TRACKS, 4, number of requesting tracks; at least 2.
- TRACK_BLOCKS, 4096, blocks reserved per track; power of two.
- TIMEOUT_CYCLES, 1000000, maximum cycles spent in WAIT_BUSY or WAIT_DONE before the transfer is aborted.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_TRACKS  per-track request, level; held until req_ack; may be withdrawn before ack
- req_write  in  NUM_TRACKS  1 = store block (SD write), 0 = load block (SD read); sampled with req_valid
- track_clear  in  NUM_TRACKS  1-cycle pulse; zeroes wr_blk and rd_blk of that track
- track_rewind  in  NUM_TRACKS  1-cycle pulse; zeroes rd_blk only
- req_ack  out  NUM_TRACKS  1-cycle pulse: request accepted
- req_done  out  NUM_TRACKS  1-cycle pulse: transfer finished or rejected
- req_err  out  NUM_TRACKS  valid with req_done: track full, end of track, or timeout
- grant_id  out  $clog2(NUM_TRACKS)  track that owns the controller; valid while busy=1
- busy  out  1  a transfer is in progress
- sd_ready  in  1  controller idle and ready
- sd_rd  out  1  read request to controller
- sd_wr  out  1  write request to controller
- sd_addr  out  32  block byte address, always a multiple of 512

Behaviour:
- Reset: all outputs 0; all wr_blk/rd_blk = 0; round-robin pointer last = NUM_TRACKS-1; state IDLE.
- Address: sd_addr = ((grant_id*TRACK_BLOCKS) + blk) << 9, truncated to 32 bits.
  - blk is wr_blk for a write and rd_blk for a read.
  - sd_addr is held stable from ISSUE through DONE.
- FSM states:
  - IDLE: if any req_valid is set, select the first set bit searching from last+1 upward with wrap. Pulse req_ack, latch grant_id/req_write/blk, set last = grant, busy=1, go to CHECK. Otherwise stay.
  - CHECK (1 cycle):
    - A write with wr_blk == TRACK_BLOCKS is rejected as full.
    - A read with rd_blk >= wr_blk is rejected as end of track.
    - Rejected: pulse req_done and req_err, go to IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: wait for sd_ready=1, then assert sd_rd or sd_wr, go to WAIT_BUSY.
  - WAIT_BUSY: hold sd_rd/sd_wr high until sd_ready=0, then deassert and go to WAIT_DONE.
  - WAIT_DONE: wait for sd_ready=1, then go to DONE.
  - DONE (1 cycle): pulse req_done; increment wr_blk (write) or rd_blk (read) of the granted track; busy=0; go to IDLE.
- Latency: ack is the cycle after req_valid is seen in IDLE. sd_rd/sd_wr rise 2 cycles after ack if sd_ready is already 1.
- Timeout: the cycle counter resets on entry to WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES: drop sd_rd/sd_wr, pulse req_done and req_err, do not increment, return to IDLE.
- Pointer widths: $clog2(TRACK_BLOCKS)+1 bits, so wr_blk can reach TRACK_BLOCKS. No wrap-around; a full track stays full until track_clear.
- Simultaneous events:
  - track_clear or track_rewind beats a DONE increment in the same cycle.
  - A clear/rewind arriving while that track's transfer is active discards the pending increment; the pointer remains 0 and done still pulses.
  - Clear/rewind on other tracks act immediately.
- Only one track is ever granted; req_ack, req_done and req_err are one-hot or zero.
- rst_n asserted mid-transfer drops sd_rd/sd_wr and busy asynchronously. The controller is reset by the same reset.

Test Plan:
- Single write: track 1, req_write=1, sd_ready=1; model drops ready 3 cycles, raises it after 20 → sd_wr high until ready falls, sd_addr=0x0000_8000 (TRACK_BLOCKS=64), req_done[1] without err, wr_blk[1]=1.
- Round robin: req_valid=4'b1111 held, ack removed per track → grant order 0,1,2,3, then 0 again on re-request; never two acks in one transfer.
- End of track: track 2 has 2 blocks written, 3 reads → addresses 0x10000 and 0x10200, third read gives req_done[2]+req_err[2] in CHECK with no sd_rd pulse.
- Full track: TRACK_BLOCKS=4, 5 writes on track 0 → 4 succeed at addresses 0x000..0x600, fifth errs; track_clear then a write succeeds at 0x000.
- Rewind race: track_rewind[3] pulsed during WAIT_DONE of track 3 read at rd_blk=5 → done pulses and rd_blk[3]=0 afterwards.
- Timeout/reset: TIMEOUT_CYCLES=50, sd_ready never falls → after 50 cycles sd_wr=0 and done+err. A separate run pulses rst_n low in WAIT_DONE → all outputs 0 immediately and pointers 0.

Source files
------------

// File: rtl/sd_block_scheduler.sv
// sd_block_scheduler
//   Shares one SD block controller between NUM_TRACKS track engines. Each
//   engine asks for one 512-byte block at a time. The scheduler keeps a
//   write pointer (track length) and a read pointer per track. It maps every
//   block into a fixed per-track region of the card and runs the controller
//   handshake.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-track request level, held until req_ack (may be withdrawn)
//   req_write       per-track direction, 1 = store (SD write), 0 = load (SD read)
//   track_clear     per-track pulse, zeroes both pointers of that track
//   track_rewind    per-track pulse, zeroes the read pointer only
//   req_ack         one-hot pulse, request accepted
//   req_done        one-hot pulse, transfer finished or rejected
//   req_err         one-hot, valid with req_done: full, end of track or timeout
//   grant_id        owning track, valid while busy
//   busy            a transfer is in progress
//   sd_ready        controller idle/ready
//   sd_rd, sd_wr    read/write request to the controller
//   sd_addr         byte address of the block (multiple of 512)
//   dbg_state       current FSM state, for observation only
//
// Controller handshake: in ISSUE the scheduler waits for sd_ready=1, then
// raises sd_rd or sd_wr. It holds that request until the controller drops
// sd_ready, which acknowledges it. A later return of sd_ready=1 marks the block
// as complete. sd_addr is stable from the request edge until the scheduler is
// back in IDLE.

module sd_block_scheduler #(
   parameter int NUM_TRACKS     = 4,
   parameter int TRACK_BLOCKS   = 4096,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_TRACKS-1:0]         req_valid,
   input  logic [NUM_TRACKS-1:0]         req_write,
   input  logic [NUM_TRACKS-1:0]         track_clear,
   input  logic [NUM_TRACKS-1:0]         track_rewind,
   output logic [NUM_TRACKS-1:0]         req_ack,
   output logic [NUM_TRACKS-1:0]         req_done,
   output logic [NUM_TRACKS-1:0]         req_err,
   output logic [$clog2(NUM_TRACKS)-1:0] grant_id,
   output logic                          busy,
   input  logic                          sd_ready,
   output logic                          sd_rd,
   output logic                          sd_wr,
   output logic [31:0]                   sd_addr,
   output logic [2:0]                    dbg_state
);

   localparam int GW = $clog2(NUM_TRACKS);
   localparam int PW = $clog2(TRACK_BLOCKS) + 1;   // pointer can reach TRACK_BLOCKS
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK     = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t                state;
   logic [PW-1:0]         wr_blk [NUM_TRACKS];
   logic [PW-1:0]         rd_blk [NUM_TRACKS];
   logic [GW-1:0]         last;
   logic [GW-1:0]         sel;
   logic                  found;
   logic [NUM_TRACKS-1:0] sel_oh;
   logic [NUM_TRACKS-1:0] grant_oh;
   logic                  cur_write;
   logic [PW-1:0]         cur_blk;
   logic                  discard;
   logic                  cancel;
   logic [CW-1:0]         cnt;
   logic [NUM_TRACKS-1:0] inc_wr;
   logic [NUM_TRACKS-1:0] inc_rd;
   logic [63:0]           addr_full;

   assign dbg_state = state;

   // Round-robin pick: first requesting track after the last granted one.
   always_comb begin
      found  = 1'b0;
      sel    = '0;
      sel_oh = '0;
      for (int i = 1; i <= NUM_TRACKS; i++) begin
         if (!found && req_valid[(int'(last) + i) % NUM_TRACKS]) begin
            found = 1'b1;
            sel   = GW'((int'(last) + i) % NUM_TRACKS);
         end
      end
      if (found) sel_oh[sel] = 1'b1;
   end

   always_comb begin
      grant_oh           = '0;
      grant_oh[grant_id] = 1'b1;
   end

   // Region base of the granted track plus the block index, in bytes.
   assign addr_full = ((64'(grant_id) * 64'(TRACK_BLOCKS)) + 64'(cur_blk)) << 9;

   // A clear (or a rewind during a read) of the owning track makes the
   // pending pointer increment meaningless; the pointer must stay at 0.
   assign cancel = track_clear[grant_id] | (~cur_write & track_rewind[grant_id]);

   assign inc_wr = (state == S_DONE && cur_write && !discard)  ? grant_oh : '0;
   assign inc_rd = (state == S_DONE && !cur_write && !discard) ? grant_oh : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last      <= GW'(NUM_TRACKS - 1);
         grant_id  <= '0;
         cur_write <= 1'b0;
         cur_blk   <= '0;
         discard   <= 1'b0;
         cnt       <= '0;
         req_ack   <= '0;
         req_done  <= '0;
         req_err   <= '0;
         busy      <= 1'b0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         sd_addr   <= '0;
      end else begin
         req_ack  <= '0;
         req_done <= '0;
         req_err  <= '0;
         if (busy && cancel) discard <= 1'b1;

         case (state)
            S_IDLE: begin
               if (found) begin
                  req_ack   <= sel_oh;
                  grant_id  <= sel;
                  cur_write <= req_write[sel];
                  cur_blk   <= req_write[sel] ? wr_blk[sel] : rd_blk[sel];
                  last      <= sel;
                  busy      <= 1'b1;
                  discard   <= 1'b0;
                  state     <= S_CHECK;
               end
            end

            S_CHECK: begin
               if ((cur_write && cur_blk == PW'(TRACK_BLOCKS)) ||
                   (!cur_write && cur_blk >= wr_blk[grant_id])) begin
                  req_done <= grant_oh;
                  req_err  <= grant_oh;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  sd_addr <= addr_full[31:0];
                  state   <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (sd_ready) begin
                  sd_wr <= cur_write;
                  sd_rd <= ~cur_write;
                  cnt   <= '0;
                  state <= S_WAIT_BUSY;
               end
            end

            S_WAIT_BUSY: begin
               if (!sd_ready) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  cnt   <= '0;
                  state <= S_WAIT_DONE;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  sd_rd    <= 1'b0;
                  sd_wr    <= 1'b0;
                  req_done <= grant_oh;
                  req_err  <= grant_oh;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_WAIT_DONE: begin
               if (sd_ready) begin
                  state <= S_DONE;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  req_done <= grant_oh;
                  req_err  <= grant_oh;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_DONE: begin
               req_done <= grant_oh;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // Track pointers: clear/rewind always win over a completing transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TRACKS; t++) begin
            wr_blk[t] <= '0;
            rd_blk[t] <= '0;
         end
      end else begin
         for (int t = 0; t < NUM_TRACKS; t++) begin
            if (track_clear[t]) begin
               wr_blk[t] <= '0;
               rd_blk[t] <= '0;
            end else begin
               if (track_rewind[t])  rd_blk[t] <= '0;
               else if (inc_rd[t])   rd_blk[t] <= rd_blk[t] + PW'(1);
               if (inc_wr[t])        wr_blk[t] <= wr_blk[t] + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_block_scheduler.sv
// tb_sd_block_scheduler
//   Bench for sd_block_scheduler with 4 tracks, 64 blocks per track and a
//   50-cycle timeout. It contains a behavioural SD controller. It also keeps
//   a transaction-level model of the track pointers and the round-robin order.

module tb_sd_block_scheduler;

   localparam int NT  = 4;
   localparam int TB  = 64;
   localparam int TO  = 50;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_write;
   logic [3:0]  track_clear;
   logic [3:0]  track_rewind;
   logic [3:0]  req_ack;
   logic [3:0]  req_done;
   logic [3:0]  req_err;
   logic [1:0]  grant_id;
   logic        busy;
   logic        sd_ready;
   logic        sd_rd;
   logic        sd_wr;
   logic [31:0] sd_addr;
   logic [2:0]  dbg_state;

   sd_block_scheduler #(
      .NUM_TRACKS    (NT),
      .TRACK_BLOCKS  (TB),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .track_clear (track_clear),
      .track_rewind(track_rewind),
      .req_ack     (req_ack),
      .req_done    (req_done),
      .req_err     (req_err),
      .grant_id    (grant_id),
      .busy        (busy),
      .sd_ready    (sd_ready),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_addr     (sd_addr),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {write, addr} of the next controller request

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int wr_m[NT];
   int rd_m[NT];
   int last_m;

   function automatic void model_reset();
      for (int t = 0; t < NT; t++) begin
         wr_m[t] = 0;
         rd_m[t] = 0;
      end
      last_m = NT - 1;
   endfunction

   function automatic int pick(input logic [3:0] v);
      for (int i = 1; i <= NT; i++)
         if (v[(last_m + i) % NT]) return (last_m + i) % NT;
      return -1;
   endfunction

   function automatic void predict(input int t, input bit w, output bit err, output logic [31:0] addr);
      int blk;
      blk  = w ? wr_m[t] : rd_m[t];
      err  = w ? (wr_m[t] == TB) : (rd_m[t] >= wr_m[t]);
      addr = 32'((t * TB + blk) * 512);
   endfunction

   function automatic void commit(input int t, input bit w);
      if (w) wr_m[t]++;
      else   rd_m[t]++;
   endfunction

   // ---------------- SD controller model ----------------
   // mode 0: normal, 1: never drops ready, 2: drops ready and never returns
   int ctl_mode;
   bit ctl_rand;

   initial begin
      int f, wk, g;
      logic [31:0] cur_addr;
      logic [32:0] e;
      sd_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && (sd_rd || sd_wr)) begin
            f  = ctl_rand ? int'($urandom_range(1, 4))  : 3;
            wk = ctl_rand ? int'($urandom_range(1, 25)) : 20;
            chk("sd_rd_wr_exclusive", sd_rd & sd_wr, 0);
            chk("sd_req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("sd_req_addr", {sd_wr, sd_addr}, e);
            end
            cur_addr = sd_addr;
            if (ctl_mode == 1) begin
               g = 0;
               while ((sd_rd || sd_wr) && g < 200) begin
                  @(negedge clk);
                  g++;
               end
            end else begin
               for (int i = 0; i < f; i++) begin
                  @(negedge clk);
                  chk("sd_req_hold", sd_rd | sd_wr, 1);
               end
               sd_ready = 1'b0;
               @(negedge clk);
               chk("sd_req_release", sd_rd | sd_wr, 0);
               if (ctl_mode == 2) begin
                  g = 0;
                  while (ctl_mode == 2 && rst_n && g < 3000) begin
                     @(negedge clk);
                     g++;
                  end
               end else begin
                  for (int i = 0; i < wk; i++) begin
                     @(negedge clk);
                     chk("sd_addr_stable", sd_addr, cur_addr);
                  end
               end
               sd_ready = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called with req_valid already driven and the DUT idle.
   task automatic serve_one(input int exp_t, input bit exp_err, input bit exp_sd,
                            input bit exp_write, input logic [31:0] exp_addr, input int exp_hi);
      int waited, cyc, first_req, hi_cnt, extra_acks;
      bit got_done;
      logic [3:0] oh;
      oh = 4'b0001 << exp_t;
      waited = 0;
      @(negedge clk);
      while (req_ack == 4'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("ack_latency", waited, 0);
      chk("ack_vec", req_ack, oh);
      chk("grant_id", grant_id, exp_t);
      chk("busy_on_ack", busy, 1);
      req_valid[exp_t] = 1'b0;
      if (exp_sd) exp_q.push_back({exp_write, exp_addr});
      cyc = 0; first_req = -1; hi_cnt = 0; extra_acks = 0; got_done = 0;
      while (!got_done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (req_ack != 4'b0) extra_acks++;
         if (sd_rd || sd_wr) begin
            hi_cnt++;
            if (first_req < 0) first_req = cyc;
         end
         if (req_done != 4'b0) got_done = 1;
      end
      chk("done_seen", got_done, 1);
      chk("done_vec", req_done, oh);
      chk("err_vec", req_err, exp_err ? oh : 4'b0);
      chk("busy_after_done", busy, 0);
      chk("single_ack", extra_acks, 0);
      chk("issue_latency", first_req, exp_sd ? 2 : -1);
      if (exp_hi >= 0) chk("req_high_cycles", hi_cnt, exp_hi);
      chk("sd_req_consumed", exp_q.size(), 0);
   endtask

   task automatic run_reqs(input logic [3:0] v, input logic [3:0] w);
      logic [3:0] pending;
      int t;
      bit err;
      logic [31:0] addr;
      pending   = v;
      req_write = w;
      req_valid = v;
      while (pending != 4'b0) begin
         t = pick(pending);
         predict(t, w[t], err, addr);
         serve_one(t, err, !err, w[t], addr, -1);
         if (!err) commit(t, w[t]);
         last_m = t;
         pending[t] = 1'b0;
      end
      req_valid = 4'b0;
   endtask

   task automatic pulse(input bit is_clear, input int t);
      if (is_clear) track_clear[t]  = 1'b1;
      else          track_rewind[t] = 1'b1;
      @(negedge clk);
      track_clear  = 4'b0;
      track_rewind = 4'b0;
      rd_m[t] = 0;
      if (is_clear) wr_m[t] = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int          trk;
      bit          wr;
      bit          err;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int g;
      bit err;
      logic [31:0] addr;

      tbl[0]  = '{1, 1'b1, 1'b0, 32'h0000_8000};
      tbl[1]  = '{2, 1'b1, 1'b0, 32'h0001_0000};
      tbl[2]  = '{2, 1'b1, 1'b0, 32'h0001_0200};
      tbl[3]  = '{2, 1'b0, 1'b0, 32'h0001_0000};
      tbl[4]  = '{2, 1'b0, 1'b0, 32'h0001_0200};
      tbl[5]  = '{2, 1'b0, 1'b1, 32'h0};
      tbl[6]  = '{3, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{0, 1'b1, 1'b0, 32'h0000_0000};
      tbl[8]  = '{0, 1'b0, 1'b0, 32'h0000_0000};
      tbl[9]  = '{1, 1'b0, 1'b0, 32'h0000_8000};
      tbl[10] = '{1, 1'b0, 1'b1, 32'h0};

      rst_n = 1'b0; req_valid = 4'b0; req_write = 4'b0;
      track_clear = 4'b0; track_rewind = 4'b0;
      ctl_mode = 0; ctl_rand = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", req_ack, 0);
      chk("rst_done", req_done, 0);
      chk("rst_err", req_err, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sd_rdwr", {sd_rd, sd_wr}, 0);
      chk("rst_sd_addr", sd_addr, 0);
      chk("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);

      // directed vectors with hand-computed addresses
      for (int i = 0; i < 11; i++) begin
         req_write = 4'b0;
         req_write[tbl[i].trk] = tbl[i].wr;
         req_valid = 4'b0001 << tbl[i].trk;
         serve_one(tbl[i].trk, tbl[i].err, !tbl[i].err, tbl[i].wr, tbl[i].addr, -1);
         predict(tbl[i].trk, tbl[i].wr, err, addr);
         if (!err) commit(tbl[i].trk, tbl[i].wr);
         last_m = tbl[i].trk;
      end

      // round robin with all tracks requesting at once
      run_reqs(4'b1111, 4'b1111);
      run_reqs(4'b1111, 4'b0000);
      run_reqs(4'b0101, 4'b0100);

      // fill track 0, overflow, then clear
      ctl_rand = 1'b1;
      g = 0;
      while (wr_m[0] < TB && g < 80) begin
         run_reqs(4'b0001, 4'b0001);
         g++;
      end
      run_reqs(4'b0001, 4'b0001);
      pulse(1'b1, 0);
      run_reqs(4'b0001, 4'b0001);

      // rewind of track 3 while its read waits for completion
      ctl_rand = 1'b0;
      while (wr_m[3] < 6) run_reqs(4'b1000, 4'b1000);
      while (rd_m[3] < 5) run_reqs(4'b1000, 4'b0000);
      req_write = 4'b0;
      req_valid = 4'b1000;
      predict(3, 1'b0, err, addr);
      chk("race_model_addr", addr, 32'h0001_8A00);
      fork
         serve_one(3, err, !err, 1'b0, addr, -1);
         begin
            int gg;
            gg = 0;
            while (dbg_state != 3'd4 && gg < 100) begin
               @(negedge clk);
               gg++;
            end
            chk("race_in_wait_done", dbg_state, 4);
            track_rewind = 4'b1000;
            track_clear  = 4'b0010;
            @(negedge clk);
            track_rewind = 4'b0;
            track_clear  = 4'b0;
         end
      join
      rd_m[3] = 0;
      wr_m[1] = 0; rd_m[1] = 0;
      last_m = 3;
      run_reqs(4'b1000, 4'b0000);
      run_reqs(4'b0010, 4'b0000);

      // randomized traffic with occasional clear/rewind
      ctl_rand = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0)
            pulse($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
         run_reqs(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
      end
      ctl_rand = 1'b0;

      // timeout in WAIT_BUSY: controller never drops ready
      ctl_mode = 1;
      req_write = 4'b0100;
      req_valid = 4'b0100;
      predict(2, 1'b1, err, addr);
      serve_one(2, 1'b1, 1'b1, 1'b1, addr, TO);
      last_m = 2;
      ctl_mode = 0;
      repeat (2) @(negedge clk);

      // timeout in WAIT_DONE: controller never returns ready
      ctl_mode = 2;
      req_write = 4'b0000;
      req_valid = 4'b0001;
      predict(0, 1'b0, err, addr);
      if (err) begin
         req_write = 4'b0001;
         predict(0, 1'b1, err, addr);
         serve_one(0, 1'b1, 1'b1, 1'b1, addr, -1);
      end else begin
         serve_one(0, 1'b1, 1'b1, 1'b0, addr, -1);
      end
      last_m = 0;
      ctl_mode = 0;
      repeat (3) @(negedge clk);
      run_reqs(4'b0100, 4'b0100);

      // reset in the middle of a transfer
      ctl_mode = 2;
      predict(1, 1'b1, err, addr);
      exp_q.push_back({1'b1, addr});
      req_write = 4'b0010;
      req_valid = 4'b0010;
      g = 0;
      @(negedge clk);
      while (req_ack == 4'b0 && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("rst_run_ack", req_ack, 4'b0010);
      req_valid = 4'b0;
      g = 0;
      while (dbg_state != 3'd4 && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("rst_run_wait_done", dbg_state, 4);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_sd_rdwr", {sd_rd, sd_wr}, 0);
      chk("arst_pulses", {req_ack, req_done, req_err}, 0);
      chk("arst_grant", grant_id, 0);
      chk("arst_sd_addr", sd_addr, 0);
      chk("arst_state", dbg_state, 0);
      ctl_mode = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      exp_q.delete();
      @(negedge clk);
      chk("post_rst_ready", sd_ready, 1);
      // pointers must be zero again: a read is end-of-track, writes start at block 0
      run_reqs(4'b0010, 4'b0000);
      run_reqs(4'b1111, 4'b1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
